// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops bytes from the transmit FIFO and sends each one as a UART
// frame, LSB first: start bit, 8 data bits, optional parity bit, one stop bit.
// The bit period is latched at every pop, so divisor changes mid-frame have no effect.
module uart_tx_drain #(
    parameter int PARITY = 0,   // 0 = none, 1 = odd, 2 = even
    parameter int DIVW   = 24
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_enable,
    input  logic [DIVW-1:0] i_clks_per_baud,
    input  logic            i_fifo_empty_n,
    input  logic [7:0]      i_fifo_data,
    output logic            o_fifo_rd,
    output logic            o_uart_tx,
    output logic            o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    localparam logic [DIVW-1:0] DIV_MIN = DIVW'(2);
    localparam logic [DIVW-1:0] ONE     = DIVW'(1);

    state_t          state;
    logic [7:0]      shift;
    logic [DIVW-1:0] div;
    logic [DIVW-1:0] cnt;
    logic [2:0]      bit_idx;
    logic            par;

    logic [DIVW-1:0] div_new;
    logic            bit_end;
    logic            par_new;

    // A one-clock bit would leave no room for the counter reload, so clamp to 2.
    assign div_new = (i_clks_per_baud < DIV_MIN) ? DIV_MIN : i_clks_per_baud;
    assign bit_end = (cnt == '0);
    assign par_new = (PARITY == 1) ? ~(^i_fifo_data) : (^i_fifo_data);

    // Pop from idle, or on the last stop clock so back-to-back frames have no gap.
    // Reset gates the strobe so the FIFO is never popped while we are held.
    assign o_fifo_rd = !i_rst && i_enable && i_fifo_empty_n &&
                       ((state == IDLE) || ((state == STOP) && bit_end));

    // Frame sequencer: state, counters, shift register and the registered line/busy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            shift     <= '0;
            div       <= '0;
            cnt       <= '0;
            bit_idx   <= '0;
            par       <= 1'b0;
            o_uart_tx <= 1'b1;
            o_busy    <= 1'b0;
        end else if (o_fifo_rd) begin
            shift     <= i_fifo_data;
            div       <= div_new;
            cnt       <= div_new - ONE;
            par       <= par_new;
            bit_idx   <= '0;
            state     <= START;
            o_uart_tx <= 1'b0;
            o_busy    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    o_uart_tx <= 1'b1;
                    o_busy    <= 1'b0;
                end
                START: begin
                    if (bit_end) begin
                        state     <= DATA;
                        cnt       <= div - ONE;
                        o_uart_tx <= shift[0];
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt     <= div - ONE;
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            if (PARITY != 0) begin
                                state     <= PAR;
                                o_uart_tx <= par;
                            end else begin
                                state     <= STOP;
                                o_uart_tx <= 1'b1;
                            end
                        end else begin
                            o_uart_tx <= shift[1];
                        end
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                PAR: begin
                    if (bit_end) begin
                        state     <= STOP;
                        cnt       <= div - ONE;
                        o_uart_tx <= 1'b1;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                STOP: begin
                    // A pending pop is handled above; reaching here on the last clock means stop.
                    if (bit_end) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_uart_tx <= 1'b1;
                    o_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: directed checks of uart_tx_drain. Three instances cover the
// three parity modes; only the selected one is enabled and drives the FIFO model.
module tb_uart_tx_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en0 = 1'b1;
    logic        en1 = 1'b0;
    logic        en2 = 1'b0;
    logic [23:0] div = 24'd4;
    logic        fifo_empty_n = 1'b0;
    logic [7:0]  fifo_data = 8'hEE;
    logic        rd0, rd1, rd2;
    logic        tx0, tx1, tx2;
    logic        busy0, busy1, busy2;

    int          sel = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          rd_cnt = 0;
    int          pops_done = 0;
    logic [7:0]  q[$];

    logic rd_sel, tx_sel, busy_sel;
    assign rd_sel   = (sel == 0) ? rd0   : (sel == 1) ? rd1   : rd2;
    assign tx_sel   = (sel == 0) ? tx0   : (sel == 1) ? tx1   : tx2;
    assign busy_sel = (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;

    uart_tx_drain #(.PARITY(0), .DIVW(24)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_enable(en0), .i_clks_per_baud(div),
        .i_fifo_empty_n(fifo_empty_n), .i_fifo_data(fifo_data),
        .o_fifo_rd(rd0), .o_uart_tx(tx0), .o_busy(busy0));
    uart_tx_drain #(.PARITY(1), .DIVW(24)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_enable(en1), .i_clks_per_baud(div),
        .i_fifo_empty_n(fifo_empty_n), .i_fifo_data(fifo_data),
        .o_fifo_rd(rd1), .o_uart_tx(tx1), .o_busy(busy1));
    uart_tx_drain #(.PARITY(2), .DIVW(24)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_enable(en2), .i_clks_per_baud(div),
        .i_fifo_empty_n(fifo_empty_n), .i_fifo_data(fifo_data),
        .o_fifo_rd(rd2), .o_uart_tx(tx2), .o_busy(busy2));

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Count pop strobes from the selected instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (rd_sel === 1'b1) rd_cnt++;
    end

    // FIFO model: apply pops just after the edge, so the empty flag lags one clock.
    always @(posedge clk) begin
        #1;
        while (pops_done < rd_cnt) begin
            if (q.size() > 0) void'(q.pop_front());
            pops_done++;
        end
        fifo_empty_n = (q.size() != 0);
        fifo_data    = (q.size() != 0) ? q[0] : 8'hEE;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_en(input logic v);
        en0 = (sel == 0) ? v : 1'b0;
        en1 = (sel == 1) ? v : 1'b0;
        en2 = (sel == 2) ? v : 1'b0;
    endtask

    // Wait (bounded) for a pop strobe; report how many negedges it took.
    task automatic wait_rd(input string tag, input int exp_lat);
        int lat = 0;
        bit seen = 0;
        while (!seen && lat < 300) begin
            @(negedge clk);
            lat++;
            if (rd_sel === 1'b1) seen = 1;
        end
        chk(tag, seen ? lat : 999, exp_lat);
    endtask

    // Called at the negedge of the pop cycle; checks every clock of the frame.
    task automatic check_frame(input string tag, input logic [7:0] b, input int d,
                               input bit has_par, input bit par_bit, input bit rd_last,
                               input int chg_idx, input int chg_div, input int drop_idx);
        int   nb = has_par ? 11 : 10;
        int   errs = 0;
        int   rd_errs = 0;
        int   bi;
        logic exp_tx;
        logic exp_rd;
        for (int k = 0; k < nb * d; k++) begin
            @(negedge clk);
            bi = k / d;
            if (bi == 0)                   exp_tx = 1'b0;
            else if (bi <= 8)              exp_tx = b[bi-1];
            else if (has_par && bi == 9)   exp_tx = par_bit;
            else                           exp_tx = 1'b1;
            if (tx_sel !== exp_tx || busy_sel !== 1'b1) errs++;
            exp_rd = (k == nb * d - 1) ? rd_last : 1'b0;
            if (rd_sel !== exp_rd) rd_errs++;
            if (k == chg_idx) div = 24'(chg_div);
            if (k == drop_idx) set_en(1'b0);
        end
        chk({tag, "_bits"}, errs, 0);
        chk({tag, "_rd"}, rd_errs, 0);
    endtask

    // Watch n idle clocks: line high, not busy, no pop.
    task automatic idle_chk(input string tag, input int n);
        int errs = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (tx_sel !== 1'b1 || busy_sel !== 1'b0 || rd_sel !== 1'b0) errs++;
        end
        chk(tag, errs, 0);
    endtask

    initial begin
        int c0;
        int errs;

        // 1. reset state, then 0x55 at D=4 with no parity
        q.push_back(8'h55);
        repeat (3) @(negedge clk);
        chk("rst_tx", tx0, 1'b1);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_rd", rd0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_rd("t1_lat", 1);
        check_frame("t1", 8'h55, 4, 0, 0, 0, -1, 0, -1);
        idle_chk("t1_idle", 1);

        // 2. back-to-back 0xA5, 0x3C at D=16
        div = 24'd16;
        q.push_back(8'hA5);
        q.push_back(8'h3C);
        c0 = rd_cnt;
        wait_rd("t2_lat", 1);
        check_frame("t2a", 8'hA5, 16, 0, 0, 1, -1, 0, -1);
        check_frame("t2b", 8'h3C, 16, 0, 0, 0, -1, 0, -1);
        idle_chk("t2_idle", 2);
        chk("t2_pops", rd_cnt - c0, 2);

        // 3. odd then even parity on 0x07 at D=8
        div = 24'd8;
        sel = 1;
        set_en(1'b1);
        q.push_back(8'h07);
        wait_rd("t3o_lat", 1);
        check_frame("t3o", 8'h07, 8, 1, 1'b0, 0, -1, 0, -1);
        idle_chk("t3o_idle", 1);
        sel = 2;
        set_en(1'b1);
        q.push_back(8'h07);
        wait_rd("t3e_lat", 1);
        check_frame("t3e", 8'h07, 8, 1, 1'b1, 0, -1, 0, -1);
        idle_chk("t3e_idle", 1);

        // 4. divisor 0 and 1 clamp to 2; mid-frame change to 10 ignored
        sel = 0;
        set_en(1'b1);
        div = 24'd0;
        q.push_back(8'h5A);
        wait_rd("t4a_lat", 1);
        check_frame("t4a", 8'h5A, 2, 0, 0, 0, -1, 0, -1);
        idle_chk("t4a_idle", 1);
        div = 24'd1;
        q.push_back(8'h96);
        wait_rd("t4b_lat", 1);
        check_frame("t4b", 8'h96, 2, 0, 0, 0, 0, 10, -1);
        idle_chk("t4b_idle", 1);

        // 5. enable dropped mid-DATA with the FIFO still holding a byte
        div = 24'd4;
        q.push_back(8'h33);
        q.push_back(8'h44);
        wait_rd("t5a_lat", 1);
        check_frame("t5a", 8'h33, 4, 0, 0, 0, -1, 0, 10);
        c0 = rd_cnt;
        idle_chk("t5_idle", 6);
        chk("t5_nopop", rd_cnt - c0, 0);
        @(posedge clk);
        #1 set_en(1'b1);
        wait_rd("t5b_lat", 1);
        check_frame("t5b", 8'h44, 4, 0, 0, 0, -1, 0, -1);
        idle_chk("t5b_idle", 1);

        // 6. asynchronous reset in the middle of a data bit
        q.push_back(8'hF0);
        q.push_back(8'h81);
        wait_rd("t6a_lat", 1);
        errs = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy_sel !== 1'b1) errs++;
        end
        chk("t6_busy_pre", errs, 0);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_tx", tx_sel, 1'b1);
        chk("t6_rst_busy", busy_sel, 1'b0);
        chk("t6_rst_rd", rd_sel, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_rd("t6b_lat", 1);
        check_frame("t6b", 8'h81, 4, 0, 0, 0, -1, 0, -1);
        idle_chk("t6b_idle", 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
